axi_traffic_gen: RTL and testbench
==================================

AXI_TRAFFIC_GEN -- requirements
Module: axi_traffic_gen

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, command address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width, a multiple of 8.
REQ-003 The block SHALL have parameter NUM_BURSTS, default 4, bursts per pass, range 1..256.
REQ-004 The block SHALL have parameter BURST_LEN, default 4, beats per burst, range 1..256.
REQ-005 The block SHALL have parameter BASE_ADDR, default 32'h0000_0020, first byte address.
REQ-006 The block SHALL have parameter SEED, default 32'hA5A5_0000, XOR key for the data pattern.
REQ-007 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request to run a write-then-read pass.
- busy, out, 1, a pass is in progress.
- done, out, 1, a pass is complete; stays high until the next accepted start.
- pass, out, 1, done and err_count==0 and no timeout.
- err_count, out, 16, saturating mismatch/response-error count.
- timeout, out, 1, the watchdog aborted the pass.
- cmd_valid, out, 1, command valid.
- cmd_ready, in, 1, command accepted.
- cmd_write, out, 1, 1=write, 0=read.
- cmd_addr, out, ADDR_WIDTH, burst start address.
- cmd_len, out, 8, BURST_LEN-1.
- cmd_wdata, out, DATA_WIDTH, write beat data.
- cmd_wstrb, out, DATA_WIDTH/8, all ones.
- cmd_wvalid, out, 1, write beat valid.
- cmd_wready, in, 1, write beat accepted.
- cmd_bvalid, in, 1, write response valid.
- cmd_rdata, in, DATA_WIDTH, read beat data.
- cmd_rvalid, in, 1, read beat valid.
- cmd_rready, out, 1, read beat accepted.
- cmd_resp, in, 2, response code qualified by cmd_bvalid or cmd_rvalid.

Function
REQ-008 The block SHALL use the states IDLE, WR_CMD, WR_DATA, WR_RESP, RD_CMD, RD_DATA, DONE.
REQ-009 A start accepted in IDLE or DONE SHALL clear err_count, timeout and done, set busy and enter WR_CMD on the next edge; start is ignored while busy.
REQ-010 For word index i=b*BURST_LEN+k (burst b, beat k), the expected data SHALL be SEED^i, with i zero-extended or truncated and SEED zero-extended or truncated to DATA_WIDTH.
REQ-011 cmd_addr for burst b SHALL be BASE_ADDR+b*BURST_LEN*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH.
REQ-012 In WR_CMD and RD_CMD, cmd_valid SHALL hold high with stable fields until cmd_valid&&cmd_ready, then the block moves to WR_DATA or RD_DATA respectively.
REQ-013 In WR_DATA, cmd_wvalid SHALL hold high with stable data; each cmd_wready beat advances k; after beat BURST_LEN-1 the block enters WR_RESP.
REQ-014 In WR_RESP, cmd_bvalid SHALL end the burst, and cmd_resp!=2'b00 increments err_count.
- If burst b<NUM_BURSTS-1, the block goes to WR_CMD for burst b+1.
- Otherwise, the block goes to RD_CMD with b=0.
REQ-015 In RD_DATA, cmd_rready SHALL be high; each cmd_rvalid beat compares cmd_rdata with the expected data, and a mismatch or cmd_resp!=0 increments err_count by 1 (one increment per beat, not two).
REQ-016 After the last read beat of burst NUM_BURSTS-1, the block SHALL enter DONE, clear busy and set done.
REQ-017 err_count SHALL saturate at 16'hFFFF.
REQ-018 cmd_wvalid, cmd_rready and cmd_valid SHALL be registered and never high outside their states.

Reset
REQ-019 On rst_n low, asynchronously: state=IDLE, all outputs 0 except cmd_len=BURST_LEN-1 and cmd_wstrb all ones; counters 0.
REQ-020 A reset mid-pass SHALL abandon the pass with no further command or beat issued; a new start is required.

Configuration
REQ-021 With TRAFFIC_GEN_TIMEOUT_EN defined, a 16-bit watchdog SHALL reset on every handshake (command, write beat, bvalid, read beat).
- If busy with no handshake for 1024 consecutive cycles, the block sets timeout, enters DONE, and pass stays 0.
REQ-022 Without TRAFFIC_GEN_TIMEOUT_EN, no watchdog logic SHALL exist, timeout SHALL be tied 0, and the block waits indefinitely.

Verification
REQ-023 The bench SHALL cover a default-parameter pass against a memory slave: start -> 4 writes of 4 beats from 0x20, data A5A50000..A5A5000F, then 4 reads; done=1, pass=1, err_count=0.
REQ-024 The bench SHALL cover corruption: the slave flips bit 0 of read word 5 -> err_count=1, pass=0.
REQ-025 The bench SHALL cover backpressure: cmd_ready/cmd_wready/cmd_rvalid randomly low 50% -> identical pass result, and command fields stable while cmd_valid&&!cmd_ready.
REQ-026 The bench SHALL cover SLVERR: cmd_resp=2'b10 on every bvalid -> err_count=NUM_BURSTS.
REQ-027 The bench SHALL cover reset during RD_DATA: assert rst_n low -> all outputs at reset values the same cycle; a following start -> a full clean pass.
REQ-028 The bench SHALL cover the watchdog with TRAFFIC_GEN_TIMEOUT_EN: cmd_ready held 0 -> timeout=1 and done=1 at 1024 cycles after cmd_valid rises.

Source files
------------

// File: rtl/axi_traffic_gen.sv
// axi_traffic_gen: self-contained AXI-style write-then-read traffic generator.
// A start pulse writes NUM_BURSTS bursts of BURST_LEN beats (data SEED^word_index)
// from BASE_ADDR, then reads the same region back and counts mismatches and
// non-OKAY responses in a saturating err_count.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       one-cycle pass request (ignored while busy)
//   busy, done, pass            pass status (done holds until the next start)
//   err_count[15:0]             saturating error count
//   timeout                     watchdog aborted the pass
//   cmd_valid/ready/write/addr/len          command channel
//   cmd_wdata/wstrb/wvalid/wready           write beat channel
//   cmd_bvalid                              write response
//   cmd_rdata/rvalid/rready                 read beat channel
//   cmd_resp[1:0]                           response code for bvalid/rvalid
//
// Optional feature macro: TRAFFIC_GEN_TIMEOUT_EN enables a 1024-cycle
// no-handshake watchdog; without it timeout is tied low.
module axi_traffic_gen #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BURSTS = 4,
    parameter int unsigned BURST_LEN  = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0020,
    parameter logic [31:0] SEED       = 32'hA5A5_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [15:0]               err_count,
    output logic                      timeout,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic                      cmd_write,
    output logic [ADDR_WIDTH-1:0]     cmd_addr,
    output logic [7:0]                cmd_len,
    output logic [DATA_WIDTH-1:0]     cmd_wdata,
    output logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      cmd_wvalid,
    input  logic                      cmd_wready,
    input  logic                      cmd_bvalid,
    input  logic [DATA_WIDTH-1:0]     cmd_rdata,
    input  logic                      cmd_rvalid,
    output logic                      cmd_rready,
    input  logic [1:0]                cmd_resp
);

    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned BURST_BYTES = BURST_LEN * STRB_WIDTH;
    localparam int unsigned WD_LIMIT    = 1023;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_CMD  = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_CMD  = 3'd4,
        RD_DATA = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_pass;
    logic [15:0]             r_err_count;
    logic                    r_cmd_valid;
    logic                    r_cmd_write;
    logic [ADDR_WIDTH-1:0]   r_cmd_addr;
    logic [DATA_WIDTH-1:0]   r_cmd_wdata;
    logic                    r_cmd_wvalid;
    logic                    r_cmd_rready;
    logic [7:0]              r_burst;
    logic [7:0]              r_beat;
    logic [31:0]             r_idx;      // word index b*BURST_LEN+k of the current beat

    logic                    w_last_beat;
    logic                    w_last_burst;
    logic                    w_rd_bad;
    logic                    w_err_inc;
    logic [15:0]             w_err_next;
    logic                    w_wd_expire;

    // Expected data word for a given word index
    function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [31:0] idx);
        return DATA_WIDTH'(SEED) ^ DATA_WIDTH'(idx);
    endfunction

    assign w_last_beat  = (r_beat == 8'(BURST_LEN - 1));
    assign w_last_burst = (r_burst == 8'(NUM_BURSTS - 1));

    // A bad read beat counts once whether the data, the response, or both are wrong
    assign w_rd_bad   = (cmd_rdata != f_pattern(r_idx)) || (cmd_resp != 2'b00);
    assign w_err_inc  = ((r_state == WR_RESP) && cmd_bvalid && (cmd_resp != 2'b00)) ||
                        ((r_state == RD_DATA) && cmd_rvalid && w_rd_bad);
    assign w_err_next = (w_err_inc && (r_err_count != 16'hFFFF)) ? r_err_count + 16'd1
                                                                  : r_err_count;

`ifdef TRAFFIC_GEN_TIMEOUT_EN
    logic        r_timeout;
    logic [15:0] r_wd;
    logic        w_hs;

    assign w_hs = (r_cmd_valid && cmd_ready) || (r_cmd_wvalid && cmd_wready) ||
                  ((r_state == WR_RESP) && cmd_bvalid) ||
                  ((r_state == RD_DATA) && cmd_rvalid);
    assign w_wd_expire = r_busy && !w_hs && (r_wd == 16'(WD_LIMIT));
    assign timeout     = r_timeout;

    // Watchdog: counts busy cycles since the last handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd      <= 16'd0;
            r_timeout <= 1'b0;
        end else if (start && ((r_state == IDLE) || (r_state == DONE))) begin
            r_wd      <= 16'd0;
            r_timeout <= 1'b0;
        end else if (w_wd_expire) begin
            r_wd      <= 16'd0;
            r_timeout <= 1'b1;
        end else if (r_busy) begin
            r_wd      <= w_hs ? 16'd0 : r_wd + 16'd1;
        end
    end
`else
    assign w_wd_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    // Main pass sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= 16'd0;
            r_cmd_valid  <= 1'b0;
            r_cmd_write  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_cmd_wvalid <= 1'b0;
            r_cmd_rready <= 1'b0;
            r_burst      <= 8'd0;
            r_beat       <= 8'd0;
            r_idx        <= 32'd0;
        end else if (w_wd_expire) begin
            r_state      <= DONE;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_pass       <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_wvalid <= 1'b0;
            r_cmd_rready <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= WR_CMD;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_count <= 16'd0;
                        r_cmd_valid <= 1'b1;
                        r_cmd_write <= 1'b1;
                        r_cmd_addr  <= ADDR_WIDTH'(BASE_ADDR);
                        r_burst     <= 8'd0;
                        r_beat      <= 8'd0;
                        r_idx       <= 32'd0;
                    end
                end
                WR_CMD: begin
                    if (cmd_ready) begin
                        r_cmd_valid  <= 1'b0;
                        r_cmd_wvalid <= 1'b1;
                        r_cmd_wdata  <= f_pattern(r_idx);
                        r_state      <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (cmd_wready) begin
                        r_idx <= r_idx + 32'd1;
                        if (w_last_beat) begin
                            r_beat       <= 8'd0;
                            r_cmd_wvalid <= 1'b0;
                            r_state      <= WR_RESP;
                        end else begin
                            r_beat      <= r_beat + 8'd1;
                            r_cmd_wdata <= f_pattern(r_idx + 32'd1);
                        end
                    end
                end
                WR_RESP: begin
                    if (cmd_bvalid) begin
                        r_err_count <= w_err_next;
                        r_cmd_valid <= 1'b1;
                        if (w_last_burst) begin
                            // Read phase restarts from burst 0 / word 0
                            r_burst     <= 8'd0;
                            r_idx       <= 32'd0;
                            r_cmd_addr  <= ADDR_WIDTH'(BASE_ADDR);
                            r_cmd_write <= 1'b0;
                            r_state     <= RD_CMD;
                        end else begin
                            r_burst    <= r_burst + 8'd1;
                            r_cmd_addr <= r_cmd_addr + ADDR_WIDTH'(BURST_BYTES);
                            r_state    <= WR_CMD;
                        end
                    end
                end
                RD_CMD: begin
                    if (cmd_ready) begin
                        r_cmd_valid  <= 1'b0;
                        r_cmd_rready <= 1'b1;
                        r_state      <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (cmd_rvalid) begin
                        r_err_count <= w_err_next;
                        r_idx       <= r_idx + 32'd1;
                        if (w_last_beat) begin
                            r_beat       <= 8'd0;
                            r_cmd_rready <= 1'b0;
                            if (w_last_burst) begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_pass  <= (w_err_next == 16'd0);
                            end else begin
                                r_burst     <= r_burst + 8'd1;
                                r_cmd_addr  <= r_cmd_addr + ADDR_WIDTH'(BURST_BYTES);
                                r_cmd_valid <= 1'b1;
                                r_state     <= RD_CMD;
                            end
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign cmd_valid  = r_cmd_valid;
    assign cmd_write  = r_cmd_write;
    assign cmd_addr   = r_cmd_addr;
    assign cmd_len    = 8'(BURST_LEN - 1);
    assign cmd_wdata  = r_cmd_wdata;
    assign cmd_wstrb  = '1;
    assign cmd_wvalid = r_cmd_wvalid;
    assign cmd_rready = r_cmd_rready;

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Testbench for axi_traffic_gen: memory-slave model with optional backpressure,
// read corruption and error responses; table-driven and randomized passes,
// reset during the read phase, and the watchdog (when compiled in).
module tb_axi_traffic_gen;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned NB   = 4;
    localparam int unsigned BL   = 4;
    localparam logic [31:0] BASE = 32'h0000_0020;
    localparam logic [31:0] SEED = 32'hA5A5_0000;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_count;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [DW-1:0] cmd_wdata;
    logic [DW/8-1:0] cmd_wstrb;
    logic          cmd_wvalid, cmd_wready, cmd_bvalid;
    logic [DW-1:0] cmd_rdata;
    logic          cmd_rvalid, cmd_rready;
    logic [1:0]    cmd_resp;

    axi_traffic_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BURSTS(NB), .BURST_LEN(BL),
        .BASE_ADDR(BASE), .SEED(SEED)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .timeout(timeout),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb), .cmd_wvalid(cmd_wvalid), .cmd_wready(cmd_wready),
        .cmd_bvalid(cmd_bvalid), .cmd_rdata(cmd_rdata), .cmd_rvalid(cmd_rvalid),
        .cmd_rready(cmd_rready), .cmd_resp(cmd_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Slave knobs
    bit         bp_en    = 1'b0;
    bit         hold_low = 1'b0;
    int         corrupt_idx = -1;
    int         rerr_idx    = -1;
    logic [1:0] bresp    = 2'b00;

    // Reference-model observations for the current pass
    int n_cmd, n_wbeat, n_rbeat;
    int wr_left, rd_left, wr_word, rd_word;
    bit b_pend, prev_stall, prev_wstall;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_write;
    logic [31:0] mem [256];

    typedef struct {
        bit         bp;
        int         corrupt;
        int         rerr;
        logic [1:0] bresp;
        int         exp_err;
        bit         exp_pass;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory slave; decides inputs at the falling edge for the next rising edge
    initial begin
        cmd_ready = 1'b0; cmd_wready = 1'b0; cmd_bvalid = 1'b0;
        cmd_rvalid = 1'b0; cmd_rdata = '0; cmd_resp = 2'b00;
        wr_left = 0; rd_left = 0; b_pend = 1'b0; prev_stall = 1'b0; prev_wstall = 1'b0;
        forever begin
            @(negedge clk);
            cmd_bvalid = 1'b0; cmd_rvalid = 1'b0; cmd_wready = 1'b0;
            cmd_resp = 2'b00; cmd_rdata = '0; cmd_ready = 1'b0;
            if (!rst_n) begin
                wr_left = 0; rd_left = 0; b_pend = 1'b0;
                prev_stall = 1'b0; prev_wstall = 1'b0;
                continue;
            end
            if (prev_stall && !timeout) begin
                chk("cmd_valid_held", cmd_valid, 1);
                chk("cmd_addr_stable", cmd_addr, prev_addr);
                chk("cmd_write_stable", cmd_write, prev_write);
            end
            if (prev_wstall && !timeout) begin
                chk("wvalid_held", cmd_wvalid, 1);
                chk("wdata_stable", cmd_wdata, prev_wdata);
            end
            chk("wvalid_outside_burst", cmd_wvalid && (wr_left == 0), 0);
            chk("rready_outside_burst", cmd_rready && (rd_left == 0), 0);

            if (b_pend) begin
                cmd_bvalid = 1'b1;
                cmd_resp   = bresp;
                b_pend     = 1'b0;
            end

            cmd_ready = hold_low ? 1'b0 : (bp_en ? 1'($urandom % 2) : 1'b1);
            if (cmd_valid && cmd_ready) begin
                chk("cmd_write", cmd_write, (n_cmd < int'(NB)) ? 1 : 0);
                chk("cmd_addr", cmd_addr, BASE + 32'((n_cmd % int'(NB)) * int'(BL) * 4));
                chk("cmd_len", cmd_len, BL - 1);
                if (cmd_write) begin
                    wr_left = BL; wr_word = int'(cmd_addr >> 2);
                end else begin
                    rd_left = BL; rd_word = int'(cmd_addr >> 2);
                end
                n_cmd++;
            end
            prev_stall = cmd_valid && !cmd_ready;
            prev_addr  = cmd_addr;
            prev_write = cmd_write;

            if (wr_left > 0) begin
                cmd_wready = bp_en ? 1'($urandom % 2) : 1'b1;
                if (cmd_wvalid && cmd_wready) begin
                    chk("wdata", cmd_wdata, SEED ^ 32'(n_wbeat));
                    chk("wstrb", cmd_wstrb, 4'hF);
                    mem[wr_word % 256] = cmd_wdata;
                    wr_word++; wr_left--; n_wbeat++;
                    if (wr_left == 0) b_pend = 1'b1;
                end
            end
            prev_wstall = cmd_wvalid && !cmd_wready;
            prev_wdata  = cmd_wdata;

            if ((rd_left > 0) && cmd_rready) begin
                cmd_rvalid = bp_en ? 1'($urandom % 2) : 1'b1;
                if (cmd_rvalid) begin
                    cmd_rdata = mem[rd_word % 256];
                    if (n_rbeat == corrupt_idx) cmd_rdata[0] = ~cmd_rdata[0];
                    if (n_rbeat == rerr_idx) cmd_resp = 2'b10;
                    rd_word++; rd_left--; n_rbeat++;
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_write"}, cmd_write, 0);
        chk({tag, "_cmd_addr"}, cmd_addr, 0);
        chk({tag, "_cmd_len"}, cmd_len, 3);
        chk({tag, "_wdata"}, cmd_wdata, 0);
        chk({tag, "_wstrb"}, cmd_wstrb, 4'hF);
        chk({tag, "_wvalid"}, cmd_wvalid, 0);
        chk({tag, "_rready"}, cmd_rready, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic run_pass(input string tag, input bit bp, input int corrupt, input int rerr,
                            input logic [1:0] br, input int exp_err, input bit exp_pass);
        int cyc;
        bp_en = bp; corrupt_idx = corrupt; rerr_idx = rerr; bresp = br; hold_low = 1'b0;
        n_cmd = 0; n_wbeat = 0; n_rbeat = 0;
        pulse_start();
        chk({tag, "_busy_after_start"}, busy, 1);
        chk({tag, "_done_cleared"}, done, 0);
        chk({tag, "_err_cleared"}, err_count, 0);
        repeat (3) @(negedge clk);
        pulse_start();
        chk({tag, "_busy_ignores_start"}, busy, 1);
        cyc = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_pass"}, pass, exp_pass);
        chk({tag, "_err_count"}, err_count, exp_err);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_n_cmd"}, n_cmd, 2 * NB);
        chk({tag, "_n_wbeat"}, n_wbeat, NB * BL);
        chk({tag, "_n_rbeat"}, n_rbeat, NB * BL);
        repeat (3) @(negedge clk);
        chk({tag, "_done_held"}, done, 1);
    endtask

    initial begin
        int cyc;
        int wd_c;
        vec_t v;

        vecs[0] = '{bp: 0, corrupt: -1, rerr: -1, bresp: 2'b00, exp_err: 0, exp_pass: 1};
        vecs[1] = '{bp: 0, corrupt:  5, rerr: -1, bresp: 2'b00, exp_err: 1, exp_pass: 0};
        vecs[2] = '{bp: 1, corrupt: -1, rerr: -1, bresp: 2'b00, exp_err: 0, exp_pass: 1};
        vecs[3] = '{bp: 0, corrupt: -1, rerr: -1, bresp: 2'b10, exp_err: 4, exp_pass: 0};
        vecs[4] = '{bp: 0, corrupt:  5, rerr:  5, bresp: 2'b00, exp_err: 1, exp_pass: 0};
        vecs[5] = '{bp: 1, corrupt:  5, rerr: 15, bresp: 2'b00, exp_err: 2, exp_pass: 0};
        vecs[6] = '{bp: 1, corrupt:  0, rerr: -1, bresp: 2'b10, exp_err: 5, exp_pass: 0};

        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        #2 rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_pass($sformatf("vec%0d", i), vecs[i].bp, vecs[i].corrupt, vecs[i].rerr,
                     vecs[i].bresp, vecs[i].exp_err, vecs[i].exp_pass);
            if (i == 0) begin
                for (int j = 0; j < 16; j++)
                    chk($sformatf("mem_word%0d", j), mem[8 + j], 32'hA5A5_0000 + 32'(j));
            end
        end

        // Randomized passes, expected result from the error-counting rules
        for (int i = 0; i < 5; i++) begin
            v.bp      = 1'($urandom % 2);
            v.corrupt = ($urandom % 3 == 0) ? -1 : int'($urandom_range(0, 15));
            v.rerr    = ($urandom % 2 == 0) ? -1 : int'($urandom_range(0, 15));
            v.bresp   = 2'($urandom % 4);
            v.exp_err = ((v.corrupt >= 0) ? 1 : 0) +
                        ((v.rerr >= 0 && v.rerr != v.corrupt) ? 1 : 0) +
                        ((v.bresp != 2'b00) ? int'(NB) : 0);
            v.exp_pass = (v.exp_err == 0);
            run_pass($sformatf("rnd%0d", i), v.bp, v.corrupt, v.rerr, v.bresp,
                     v.exp_err, v.exp_pass);
        end

        // Reset in the middle of the read phase
        bp_en = 1'b0; corrupt_idx = -1; rerr_idx = -1; bresp = 2'b00;
        n_cmd = 0; n_wbeat = 0; n_rbeat = 0;
        pulse_start();
        cyc = 0;
        while (!(cmd_rready && n_rbeat >= 6) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_reached_rd_data", cmd_rready, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_mid");
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_mid_no_cmd", cmd_valid, 0);
        chk("rst_mid_idle", busy, 0);
        run_pass("after_rst", 1'b0, -1, -1, 2'b00, 0, 1'b1);

        // Stalled command channel: watchdog fires, or the block waits forever
        hold_low = 1'b1;
        pulse_start();
        chk("wd_cmd_valid_rise", cmd_valid, 1);
        wd_c = 0;
        for (int c = 1; c <= 1100; c++) begin
            @(negedge clk);
            if (timeout) begin
                wd_c = c;
                break;
            end
        end
`ifdef TRAFFIC_GEN_TIMEOUT_EN
        chk("wd_cycles", wd_c, 1024);
        chk("wd_timeout", timeout, 1);
        chk("wd_done", done, 1);
        chk("wd_pass", pass, 0);
        chk("wd_busy", busy, 0);
        chk("wd_cmd_valid", cmd_valid, 0);
`else
        chk("wd_absent", wd_c, 0);
        chk("wd_still_busy", busy, 1);
        chk("wd_still_valid", cmd_valid, 1);
        chk("wd_not_done", done, 0);
`endif
        hold_low = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        run_pass("after_wd", 1'b1, -1, -1, 2'b00, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
